ssg_scan_ctrl: RTL and testbench

Frame-synchronous scan controller for the 4-digit common-anode seven-segment display on the Nexys board. It time-multiplexes four digits with a programmable dead-time blanking interval to suppress ghosting. It holds a double-buffered digit store: a writer updates a pending buffer through a valid/ready port and requests a commit, which lands only at a frame boundary so a number never tears mid-frame. It sits between application logic (counters, debug values) and the board pins.

---
 rtl/ssg_scan_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_ssg_scan_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssg_scan_ctrl.sv
// Four-digit seven-segment scan controller with blanking dead-time and a frame-aligned
// double-buffered digit store. Define SSG_LEADING_ZERO_BLANK_EN to blank leading zeros.
module ssg_scan_ctrl #(
   parameter int REFRESH_DIV  = 25000,
   parameter int BLANK_CYCLES = 250
) (
   input  logic       clk,
   input  logic       greset,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [1:0] wr_addr,
   input  logic [4:0] wr_data,
   input  logic       wr_commit,
   output logic       commit_busy,
   input  logic [3:0] digit_en,
   output logic [7:0] sseg_cathode,
   output logic [3:0] sseg_anode
);

   localparam int               CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic [0:0] {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } state_t;

   state_t           state_r;
   logic [1:0]       dig_r;
   logic [CNT_W-1:0] cnt_r;
   logic [19:0]      pending_r;
   logic [19:0]      display_r;
   logic             wr_ready_r;
   logic             commit_busy_r;
   logic [3:0]       anode_r;
   logic [7:0]       cathode_r;

   logic             wr_fire_s;
   logic             slot_end_s;
   logic             frame_end_s;
   logic             apply_s;
   logic [1:0]       dig_next_s;
   logic [19:0]      pending_next_s;
   logic [19:0]      display_next_s;

   function automatic logic [6:0] hex_glyph(input logic [3:0] v);
      logic [6:0] g;
      case (v)
         4'h0:    g = 7'h40;
         4'h1:    g = 7'h79;
         4'h2:    g = 7'h24;
         4'h3:    g = 7'h30;
         4'h4:    g = 7'h19;
         4'h5:    g = 7'h12;
         4'h6:    g = 7'h02;
         4'h7:    g = 7'h78;
         4'h8:    g = 7'h00;
         4'h9:    g = 7'h10;
         4'hA:    g = 7'h08;
         4'hB:    g = 7'h03;
         4'hC:    g = 7'h46;
         4'hD:    g = 7'h21;
         4'hE:    g = 7'h06;
         4'hF:    g = 7'h0E;
         default: g = 7'h7F;
      endcase
      return g;
   endfunction

   // A digit is a leading zero when it and every higher digit hold value 0 with dp off.
   function automatic logic [7:0] digit_pattern(input logic [19:0] buf_v, input logic [1:0] d);
      logic [4:0] v;
      logic       blank;
      v     = buf_v[5*int'(d) +: 5];
      blank = 1'b0;
`ifdef SSG_LEADING_ZERO_BLANK_EN
      case (d)
         2'd3:    blank = (buf_v[19:15] == 5'd0);
         2'd2:    blank = (buf_v[19:10] == 10'd0);
         2'd1:    blank = (buf_v[19:5] == 15'd0);
         default: blank = 1'b0;
      endcase
`endif
      if (blank) begin
         return 8'hFF;
      end else begin
         return {~v[4], hex_glyph(v[3:0])};
      end
   endfunction

   function automatic logic [3:0] drive_anode(input logic [1:0] d, input logic [3:0] en);
      if (en[d]) begin
         return ~(4'b0001 << d);
      end else begin
         return 4'hF;
      end
   endfunction

   // Next-cycle buffer contents, so a write and a commit on the same edge land together
   always_comb begin
      wr_fire_s      = wr_valid && wr_ready_r;
      slot_end_s     = (state_r == ST_DRIVE) && (cnt_r == CNT_LAST);
      frame_end_s    = slot_end_s && (dig_r == 2'd3);
      apply_s        = frame_end_s && (commit_busy_r || wr_commit);
      dig_next_s     = dig_r + 2'd1;
      pending_next_s = pending_r;
      for (int i = 0; i < 4; i++) begin
         if (wr_fire_s && (wr_addr == 2'(i))) begin
            pending_next_s[5*i +: 5] = wr_data;
         end else begin
            pending_next_s[5*i +: 5] = pending_r[5*i +: 5];
         end
      end
      if (apply_s) begin
         display_next_s = pending_next_s;
      end else begin
         display_next_s = display_r;
      end
   end

   // Slot sequencing, digit store and registered pin drive
   always_ff @(posedge clk or posedge greset) begin
      if (greset) begin
         state_r       <= ST_BLANK;
         dig_r         <= 2'd0;
         cnt_r         <= '0;
         pending_r     <= 20'd0;
         display_r     <= 20'd0;
         wr_ready_r    <= 1'b1;
         commit_busy_r <= 1'b0;
         anode_r       <= 4'hF;
         cathode_r     <= 8'hFF;
      end else begin
         pending_r <= pending_next_s;
         display_r <= display_next_s;

         if (apply_s) begin
            commit_busy_r <= 1'b0;
            wr_ready_r    <= 1'b1;
         end else if (wr_commit && !commit_busy_r) begin
            commit_busy_r <= 1'b1;
            wr_ready_r    <= 1'b0;
         end else begin
            commit_busy_r <= commit_busy_r;
            wr_ready_r    <= wr_ready_r;
         end

         case (state_r)
            ST_BLANK: begin
               cnt_r <= cnt_r + CNT_ONE;
               if (cnt_r == BLANK_LAST) begin
                  state_r <= ST_DRIVE;
                  anode_r <= drive_anode(dig_r, digit_en);
               end else begin
                  anode_r <= 4'hF;
               end
            end
            ST_DRIVE: begin
               if (slot_end_s) begin
                  // Cathode settles during the blank interval, before the anode opens
                  state_r   <= ST_BLANK;
                  dig_r     <= dig_next_s;
                  cnt_r     <= '0;
                  anode_r   <= 4'hF;
                  cathode_r <= digit_pattern(display_next_s, dig_next_s);
               end else begin
                  cnt_r   <= cnt_r + CNT_ONE;
                  anode_r <= drive_anode(dig_r, digit_en);
               end
            end
            default: begin
               state_r <= ST_BLANK;
               cnt_r   <= '0;
               anode_r <= 4'hF;
            end
         endcase
      end
   end

   assign wr_ready     = wr_ready_r;
   assign commit_busy  = commit_busy_r;
   assign sseg_anode   = anode_r;
   assign sseg_cathode = cathode_r;

endmodule

// File: tb/tb_ssg_scan_ctrl.sv
// Scoreboard bench for ssg_scan_ctrl: a time-indexed reference model predicts every cycle's
// outputs, and directed spot checks cover the documented scenarios.
module tb_ssg_scan_ctrl;

   localparam int R = 8;
   localparam int B = 2;

   localparam logic [1:0] K_CATH  = 2'd0;
   localparam logic [1:0] K_ANODE = 2'd1;
   localparam logic [1:0] K_BUSY  = 2'd2;
   localparam logic [1:0] K_TOUT  = 2'd3;

   localparam logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                         8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   logic       clk = 1'b0;
   logic       greset = 1'b1;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [1:0] wr_addr = 2'd0;
   logic [4:0] wr_data = 5'd0;
   logic       wr_commit = 1'b0;
   logic       commit_busy;
   logic [3:0] digit_en = 4'hF;
   logic [7:0] sseg_cathode;
   logic [3:0] sseg_anode;

   typedef struct packed {
      logic [3:0] an;
      logic [7:0] ca;
      logic       rdy;
      logic       busy;
   } exp_t;

   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] val;
      logic [7:0] id;
   } dir_t;

   exp_t sb_q [$];
   dir_t dir_q [$];
   int   checks = 0;
   int   errors = 0;

   int              t = 0;
   logic [3:0][4:0] m_pend;
   logic [3:0][4:0] m_disp;
   logic            m_busy;
   logic [7:0]      m_cath;

   ssg_scan_ctrl #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
      .clk(clk), .greset(greset), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_commit(wr_commit),
      .commit_busy(commit_busy), .digit_en(digit_en),
      .sseg_cathode(sseg_cathode), .sseg_anode(sseg_anode)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] exp_cath(input logic [3:0][4:0] disp, input int d);
      int lz;
      lz = 0;
`ifdef SSG_LEADING_ZERO_BLANK_EN
      for (int k = 3; k >= 1; k--) begin
         if (disp[k] == 5'd0 && lz == 3 - k) lz++;
      end
`endif
      if (d > 0 && d > 3 - lz) return 8'hFF;
      return GLYPH[disp[d][3:0]] & (disp[d][4] ? 8'h7F : 8'hFF);
   endfunction

   function automatic logic [7:0] lead_zero_exp();
`ifdef SSG_LEADING_ZERO_BLANK_EN
      return 8'hFF;
`else
      return 8'hC0;
`endif
   endfunction

   // Reference model: t counts edges since reset release; slot = t / R, offset = t % R
   initial begin : model
      exp_t e;
      int   d;
      int   off;
      forever begin
         @(posedge clk);
         if (greset) begin
            t      = 0;
            m_pend = '0;
            m_disp = '0;
            m_busy = 1'b0;
            m_cath = 8'hFF;
            sb_q.delete();
            e.an   = 4'hF;
         end else begin
            if (wr_valid && !m_busy) m_pend[wr_addr] = wr_data;
            t++;
            d   = (t / R) % 4;
            off = t % R;
            if (off == 0 && d == 0 && (m_busy || wr_commit)) begin
               m_disp = m_pend;
               m_busy = 1'b0;
            end else if (wr_commit && !m_busy) begin
               m_busy = 1'b1;
            end
            if (off == 0) m_cath = exp_cath(m_disp, d);
            e.an = (off < B || !digit_en[d]) ? 4'hF : ~(4'b0001 << d);
         end
         e.ca   = m_cath;
         e.rdy  = !m_busy;
         e.busy = m_busy;
         sb_q.push_back(e);
      end
   end

   // Monitor: compares every cycle against the scoreboard and serves directed spot checks
   initial begin : monitor
      exp_t       e;
      dir_t       dx;
      logic [7:0] got;
      forever begin
         @(posedge clk or posedge greset);
         #2;
         if (!clk) begin
            checks++;
            if (sseg_anode !== 4'hF || sseg_cathode !== 8'hFF || commit_busy !== 1'b0 || wr_ready !== 1'b1) begin
               errors++;
               $display("FAIL async_reset got an=%h ca=%h busy=%b rdy=%b exp an=F ca=FF busy=0 rdy=1",
                        sseg_anode, sseg_cathode, commit_busy, wr_ready);
            end
         end else begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard_empty got no expectation exp one per cycle");
            end else begin
               e = sb_q.pop_front();
               if ({sseg_anode, sseg_cathode, wr_ready, commit_busy} !== e) begin
                  errors++;
                  $display("FAIL scan t=%0d got an=%h ca=%h rdy=%b busy=%b exp an=%h ca=%h rdy=%b busy=%b",
                           t, sseg_anode, sseg_cathode, wr_ready, commit_busy, e.an, e.ca, e.rdy, e.busy);
               end
            end
            while (dir_q.size() > 0) begin
               dx = dir_q.pop_front();
               checks++;
               case (dx.kind)
                  K_CATH:  got = sseg_cathode;
                  K_ANODE: got = {4'h0, sseg_anode};
                  K_BUSY:  got = {7'h00, commit_busy};
                  default: got = 8'h00;
               endcase
               if (got !== dx.val) begin
                  errors++;
                  $display("FAIL spot_%0d kind=%0d got %h exp %h", dx.id, dx.kind, got, dx.val);
               end
            end
         end
      end
   end

   task automatic push_dir(input logic [1:0] k, input logic [7:0] v, input logic [7:0] id);
      dir_t x;
      x.kind = k;
      x.val  = v;
      x.id   = id;
      dir_q.push_back(x);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_write(input logic [1:0] a, input logic [4:0] v);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = v;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic do_commit();
      wr_commit = 1'b1;
      @(negedge clk);
      wr_commit = 1'b0;
   endtask

   task automatic wait_slot(input int d, input logic [7:0] id);
      int n;
      n = 0;
      while (!(((t / R) % 4) == d && (t % R) == B) && n < 8 * R) begin
         @(negedge clk);
         n++;
      end
      if (n >= 8 * R) push_dir(K_TOUT, 8'h01, id);
   endtask

   task automatic wait_idle(input logic [7:0] id);
      int n;
      n = 0;
      while (commit_busy && n < 24 * R) begin
         @(negedge clk);
         n++;
      end
      if (commit_busy) push_dir(K_TOUT, 8'h01, id);
   endtask

   initial begin : stim
      logic [7:0] exp4 [4];
      int         n;
      exp4 = '{8'hF9, 8'hA4, 8'hB0, 8'h99};

      cyc(3);
      greset = 1'b0;
      cyc(40);

      // Digits 1..4 committed mid-frame
      do_write(2'd0, 5'h01);
      do_write(2'd1, 5'h02);
      do_write(2'd2, 5'h03);
      do_write(2'd3, 5'h04);
      wait_slot(1, 8'd1);
      do_commit();
      push_dir(K_BUSY, 8'h01, 8'd2);
      wait_idle(8'd3);
      for (int d = 0; d < 4; d++) begin
         wait_slot(d, 8'd4);
         push_dir(K_CATH, exp4[d], 8'(10 + d));
      end

      // Writes while busy are dropped, including across a second commit
      wait_slot(1, 8'd5);
      do_commit();
      do_write(2'd0, 5'h18);
      do_write(2'd1, 5'h1F);
      wait_idle(8'd6);
      wait_slot(0, 8'd7);
      push_dir(K_CATH, 8'hF9, 8'd20);
      wait_slot(1, 8'd8);
      push_dir(K_CATH, 8'hA4, 8'd21);
      do_commit();
      wait_idle(8'd9);
      wait_slot(0, 8'd7);
      push_dir(K_CATH, 8'hF9, 8'd22);
      wait_slot(1, 8'd8);
      push_dir(K_CATH, 8'hA4, 8'd23);

      // Write plus commit on the last cycle of the frame lands on the very next edge
      n = 0;
      while ((t % (4 * R)) != (4 * R - 1) && n < 8 * R) begin
         @(negedge clk);
         n++;
      end
      if (n >= 8 * R) push_dir(K_TOUT, 8'h01, 8'd30);
      wr_valid  = 1'b1;
      wr_addr   = 2'd0;
      wr_data   = 5'h0A;
      wr_commit = 1'b1;
      @(negedge clk);
      wr_valid  = 1'b0;
      wr_commit = 1'b0;
      push_dir(K_BUSY, 8'h00, 8'd31);
      wait_slot(0, 8'd32);
      push_dir(K_CATH, 8'h88, 8'd33);

      // Disabled digits keep their anodes off without disturbing slot timing
      digit_en = 4'b0101;
      wait_slot(1, 8'd40);
      push_dir(K_ANODE, 8'h0F, 8'd41);
      wait_slot(2, 8'd42);
      push_dir(K_ANODE, 8'h0B, 8'd43);
      wait_slot(3, 8'd44);
      push_dir(K_ANODE, 8'h0F, 8'd45);
      cyc(4 * R);
      digit_en = 4'hF;

      for (int i = 0; i < 800; i++) begin
         wr_valid  = 1'($urandom_range(0, 1));
         wr_addr   = 2'($urandom_range(0, 3));
         wr_data   = 5'($urandom_range(0, 31));
         wr_commit = ($urandom_range(0, 15) == 0);
         if (i % 37 == 0) digit_en = 4'($urandom_range(0, 15));
         @(negedge clk);
      end
      wr_valid  = 1'b0;
      wr_commit = 1'b0;
      digit_en  = 4'hF;

      // Reset in DRIVE(2) with a commit outstanding
      wait_slot(1, 8'd50);
      do_commit();
      wait_slot(2, 8'd51);
      push_dir(K_BUSY, 8'h01, 8'd52);
      @(negedge clk);
      #1;
      greset = 1'b1;
      cyc(3);
      greset = 1'b0;
      cyc(4 * R);
      wait_slot(0, 8'd53);
      push_dir(K_CATH, 8'hC0, 8'd54);
      wait_slot(1, 8'd55);
      push_dir(K_CATH, lead_zero_exp(), 8'd56);
      wait_slot(3, 8'd57);
      push_dir(K_CATH, lead_zero_exp(), 8'd58);

      // 0x0007: leading zeros blank only when the feature is built in
      do_write(2'd0, 5'h07);
      do_write(2'd1, 5'h00);
      do_write(2'd2, 5'h00);
      do_write(2'd3, 5'h00);
      wait_slot(1, 8'd60);
      do_commit();
      wait_idle(8'd61);
      wait_slot(0, 8'd62);
      push_dir(K_CATH, 8'hF8, 8'd63);
      for (int d = 1; d < 4; d++) begin
         wait_slot(d, 8'd64);
         push_dir(K_CATH, lead_zero_exp(), 8'(70 + d));
      end

      cyc(4);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
